router_fsm_np: RTL and testbench

Parametrised control FSM for the next-generation 1xN packet router. It generalises the 1x3 router FSM to N_PORTS destinations and indexes the per-port full/empty/soft-reset vectors internally by the latched destination. Two behaviours are new: invalid-address packet drop, and a WAIT_TILL_EMPTY timeout. It sits between the header decoder/parity checker and the N output FIFOs/synchroniser, and drives register-block load strobes and the source busy flag.

---
 rtl/router_fsm_np.sv | 171 +++++++++++++++++
 tb/tb_router_fsm_np.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm_np.sv
// Control FSM for a 1xN packet router: steers one packet at a time to the latched
// destination FIFO, drops packets with an out-of-range address or a stuck destination.
module router_fsm_np #(
    parameter int N_PORTS      = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 32,
    parameter int TO_W         = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pkt_valid,
    input  logic [ADDR_W-1:0]  data_in,
    input  logic               parity_done,
    input  logic               low_pkt_valid,
    input  logic [N_PORTS-1:0] fifo_full,
    input  logic [N_PORTS-1:0] fifo_empty,
    input  logic [N_PORTS-1:0] soft_reset,
    output logic               busy,
    output logic               detect_add,
    output logic               lfd_state,
    output logic               ld_state,
    output logic               laf_state,
    output logic               full_state,
    output logic               write_enb_reg,
    output logic               rst_int_reg,
    output logic               drop_state,
    output logic [N_PORTS-1:0] dest_sel,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        ST_DA   = 4'd0,
        ST_LFD  = 4'd1,
        ST_WTE  = 4'd2,
        ST_LD   = 4'd3,
        ST_FFS  = 4'd4,
        ST_LP   = 4'd5,
        ST_LAF  = 4'd6,
        ST_CPE  = 4'd7,
        ST_DROP = 4'd8
    } state_t;

    localparam int              NPAD       = 1 << ADDR_W;
    localparam logic [ADDR_W:0] NP_L       = (ADDR_W+1)'(N_PORTS);
    localparam bit              TIMEOUT_EN = (WAIT_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic              dest_vld_q, dest_vld_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;

    // Per-port vectors padded to the full address space so any address indexes safely.
    logic [NPAD-1:0] full_pad, empty_pad, sr_pad;
    logic            addr_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NPAD; gi++) begin : g_pad
            if (gi < N_PORTS) begin : g_real
                assign full_pad[gi]  = fifo_full[gi];
                assign empty_pad[gi] = fifo_empty[gi];
                assign sr_pad[gi]    = soft_reset[gi];
            end else begin : g_none
                assign full_pad[gi]  = 1'b0;
                assign empty_pad[gi] = 1'b0;
                assign sr_pad[gi]    = 1'b0;
            end
        end
        for (gi = 0; gi < N_PORTS; gi++) begin : g_sel
            assign dest_sel[gi] = dest_vld_q && (dest_q == ADDR_W'(gi));
        end
    endgenerate

    assign addr_ok = ({1'b0, data_in} < NP_L);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_DA;
            dest_q     <= '0;
            dest_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            dest_vld_q <= dest_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        dest_vld_d = dest_vld_q;
        cnt_d      = '0;

        if (state_q == ST_DA && pkt_valid && addr_ok) begin
            dest_d     = data_in;
            dest_vld_d = 1'b1;
        end

        // Counter rests at zero outside WTE, so it starts from zero on every entry.
        if (state_q == ST_WTE) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end

        if (state_q != ST_DA && state_q != ST_DROP && sr_pad[dest_q]) begin
            state_d = ST_DA;
        end else begin
            case (state_q)
                ST_DA: begin
                    if (pkt_valid) begin
                        if (!addr_ok)                state_d = ST_DROP;
                        else if (empty_pad[data_in]) state_d = ST_LFD;
                        else                         state_d = ST_WTE;
                    end
                end
                ST_LFD: state_d = ST_LD;
                ST_WTE: begin
                    if (empty_pad[dest_q])                      state_d = ST_LFD;
                    else if (TIMEOUT_EN && cnt_q == TO_LAST)    state_d = ST_DROP;
                end
                ST_LD: begin
                    if (full_pad[dest_q]) state_d = ST_FFS;
                    else if (!pkt_valid)  state_d = ST_LP;
                end
                ST_FFS: begin
                    if (!full_pad[dest_q]) state_d = ST_LAF;
                end
                ST_LAF: begin
                    if (parity_done)        state_d = ST_DA;
                    else if (low_pkt_valid) state_d = ST_LP;
                    else                    state_d = ST_LD;
                end
                ST_LP:  state_d = ST_CPE;
                ST_CPE: state_d = full_pad[dest_q] ? ST_FFS : ST_DA;
                ST_DROP: begin
                    if (!pkt_valid) state_d = ST_DA;
                end
                default: state_d = ST_DA;
            endcase
        end
    end

    always_comb begin
        busy          = 1'b0;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        drop_state    = 1'b0;
        case (state_q)
            ST_DA:   detect_add = 1'b1;
            ST_LFD:  begin lfd_state = 1'b1;  busy = 1'b1; end
            ST_WTE:  busy = 1'b1;
            ST_LD:   begin ld_state = 1'b1;   write_enb_reg = 1'b1; end
            ST_FFS:  begin full_state = 1'b1; busy = 1'b1; end
            ST_LP:   begin busy = 1'b1;       write_enb_reg = 1'b1; end
            ST_LAF:  begin laf_state = 1'b1;  busy = 1'b1; write_enb_reg = 1'b1; end
            ST_CPE:  begin rst_int_reg = 1'b1; busy = 1'b1; end
            ST_DROP: drop_state = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_router_fsm_np.sv
// Bench for router_fsm_np: directed scenarios followed by random traffic, all
// compared each cycle against a packet-level reference model.
module tb_router_fsm_np;
    localparam int NP = 3;
    localparam int AW = 2;
    localparam int WT = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, pkt_valid, parity_done, low_pkt_valid;
    logic [AW-1:0] data_in;
    logic [NP-1:0] fifo_full, fifo_empty, soft_reset;
    logic          busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic          write_enb_reg, rst_int_reg, drop_state;
    logic [NP-1:0] dest_sel;
    logic [3:0]    state;

    logic       r8, pv8, pd8, lpv8;
    logic [2:0] di8;
    logic [7:0] full8, empty8, sr8, dsel8;
    logic       busy8, da8, lfd8, ld8, laf8, ffs8, wr8, ri8, drop8;
    logic [3:0] st8;

    router_fsm_np #(.N_PORTS(NP), .ADDR_W(AW), .WAIT_TIMEOUT(WT), .TO_W(6)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .drop_state(drop_state), .dest_sel(dest_sel), .state(state)
    );

    router_fsm_np #(.N_PORTS(8), .ADDR_W(3), .WAIT_TIMEOUT(WT), .TO_W(6)) dut8 (
        .clock(clock), .reset(r8), .pkt_valid(pv8), .data_in(di8),
        .parity_done(pd8), .low_pkt_valid(lpv8),
        .fifo_full(full8), .fifo_empty(empty8), .soft_reset(sr8),
        .busy(busy8), .detect_add(da8), .lfd_state(lfd8), .ld_state(ld8),
        .laf_state(laf8), .full_state(ffs8), .write_enb_reg(wr8),
        .rst_int_reg(ri8), .drop_state(drop8), .dest_sel(dsel8), .state(st8)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: packet phase, chosen port, and time spent waiting for the port.
    int m_state = 0;
    int m_dest  = 0;
    bit m_lat   = 1'b0;
    int m_wait  = 0;
    bit m_ok    = 1'b0;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_update();
        int ns;
        if (reset) begin
            m_state = 0; m_dest = 0; m_lat = 1'b0; m_wait = 0; m_ok = 1'b1;
            return;
        end
        ns = m_state;
        if (!(m_state inside {0, 8}) && soft_reset[m_dest]) begin
            ns = 0;
        end else begin
            case (m_state)
                0: if (pkt_valid) ns = (int'(data_in) >= NP) ? 8 : (fifo_empty[data_in] ? 1 : 2);
                1: ns = 3;
                2: if (fifo_empty[m_dest]) ns = 1;
                   else if (WT != 0 && m_wait == WT - 1) ns = 8;
                3: ns = fifo_full[m_dest] ? 4 : (!pkt_valid ? 5 : 3);
                4: ns = fifo_full[m_dest] ? 4 : 6;
                6: ns = parity_done ? 0 : (low_pkt_valid ? 5 : 3);
                5: ns = 7;
                7: ns = fifo_full[m_dest] ? 4 : 0;
                8: ns = pkt_valid ? 8 : 0;
                default: ns = 0;
            endcase
        end
        if (m_state == 0 && pkt_valid && int'(data_in) < NP) begin
            m_dest = int'(data_in);
            m_lat  = 1'b1;
        end
        m_wait  = (m_state == 2 && ns == 2) ? m_wait + 1 : 0;
        m_state = ns;
    endtask

    task automatic step();
        logic [8:0] act_o, exp_o;
        @(posedge clock);
        model_update();
        #1;
        if (m_ok) begin
            act_o = {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
                     write_enb_reg, rst_int_reg, drop_state};
            exp_o = {m_state inside {1, 2, 4, 5, 6, 7}, m_state == 0, m_state == 1, m_state == 3,
                     m_state == 6, m_state == 4, m_state inside {3, 5, 6}, m_state == 7, m_state == 8};
            chk("model_state", 16'(state), 16'(m_state));
            chk("model_outputs", 16'(act_o), 16'(exp_o));
            chk("model_dest_sel", 16'(dest_sel), m_lat ? 16'(1 << m_dest) : 16'h0);
        end
        $display("t=%0t rst=%0b pv=%0b din=%0d st=%0d model=%0d dsel=%b", $time, reset,
                 pkt_valid, data_in, state, m_state, dest_sel);
    endtask

    task automatic expect_st(input int code, input string tag);
        chk(tag, 16'(state), 16'(code));
    endtask

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;
        fifo_full = '0; fifo_empty = '1; soft_reset = '0;
        r8 = 1'b1; pv8 = 1'b0; di8 = '0; pd8 = 1'b0; lpv8 = 1'b0;
        full8 = '0; empty8 = '1; sr8 = '0;

        step();
        chk("reset_state", 16'(state), 16'd0);
        chk("reset_detect_add", 16'(detect_add), 16'd1);
        chk("reset_dest_sel", 16'(dest_sel), 16'd0);
        chk("reset8_state", 16'(st8), 16'd0);
        chk("reset8_dest_sel", 16'(dsel8), 16'd0);
        reset = 1'b0;

        // Normal packet to port 1: 1,3,3,5,7,0
        data_in = 2'd1; pkt_valid = 1'b1;
        step(); expect_st(1, "p1_lfd");
        step(); expect_st(3, "p1_ld");
        chk("p1_wr_in_ld", 16'(write_enb_reg), 16'd1);
        chk("p1_busy_in_ld", 16'(busy), 16'd0);
        step(); expect_st(3, "p1_ld2");
        pkt_valid = 1'b0;
        step(); expect_st(5, "p1_lp");
        chk("p1_wr_in_lp", 16'(write_enb_reg), 16'd1);
        step(); expect_st(7, "p1_cpe");
        chk("p1_wr_in_cpe", 16'(write_enb_reg), 16'd0);
        step(); expect_st(0, "p1_da");
        chk("p1_dest_sel", 16'(dest_sel), 16'h2);

        // Port 2 with full FIFO: 3,4,4,6,5,7,0
        data_in = 2'd2; pkt_valid = 1'b1;
        step(); step(); expect_st(3, "p2_ld");
        fifo_full = 3'b001;
        step(); expect_st(3, "p2_other_full_ignored");
        fifo_full = 3'b100;
        step(); expect_st(4, "p2_ffs1");
        chk("p2_full_state1", 16'(full_state), 16'd1);
        step(); expect_st(4, "p2_ffs2");
        chk("p2_full_state2", 16'(full_state), 16'd1);
        fifo_full = 3'b000; pkt_valid = 1'b0;
        step(); expect_st(6, "p2_laf");
        low_pkt_valid = 1'b1;
        step(); expect_st(5, "p2_lp");
        low_pkt_valid = 1'b0;
        step(); expect_st(7, "p2_cpe");
        step(); expect_st(0, "p2_da");

        // Wait timeout on port 0
        data_in = 2'd0; fifo_empty = 3'b110; pkt_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); expect_st(2, "to_wte");
        end
        step(); expect_st(8, "to_drop");
        chk("to_drop_flags", 16'({drop_state, busy, write_enb_reg}), 16'b100);
        pkt_valid = 1'b0;
        step(); expect_st(0, "to_da");

        // Port becomes empty on the last allowed wait cycle: empty beats timeout
        pkt_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); expect_st(2, "late_wte");
        end
        fifo_empty = 3'b111;
        step(); expect_st(1, "late_lfd");
        pkt_valid = 1'b0;
        step(); step(); step(); step(); expect_st(0, "late_da");

        // Invalid address drops, dest_sel stays at port 0
        data_in = 2'd3; pkt_valid = 1'b1;
        step(); expect_st(8, "bad_drop");
        chk("bad_dest_sel", 16'(dest_sel), 16'h1);
        step(); expect_st(8, "bad_swallow");
        pkt_valid = 1'b0;
        step(); expect_st(0, "bad_da");

        // Soft resets of port 1 from LD, WTE, FFS, LP
        data_in = 2'd1; pkt_valid = 1'b1;
        step(); step(); expect_st(3, "sr_ld");
        soft_reset = 3'b100;
        step(); expect_st(3, "sr_other_ignored");
        soft_reset = 3'b010;
        step(); expect_st(0, "sr_from_ld");
        soft_reset = 3'b000; fifo_empty = 3'b101;
        step(); expect_st(2, "sr_wte");
        soft_reset = 3'b010;
        step(); expect_st(0, "sr_from_wte");
        soft_reset = 3'b000; fifo_empty = 3'b111;
        step(); step(); fifo_full = 3'b010;
        step(); expect_st(4, "sr_ffs");
        soft_reset = 3'b010;
        step(); expect_st(0, "sr_from_ffs");
        soft_reset = 3'b000; fifo_full = 3'b000;
        step(); step(); pkt_valid = 1'b0;
        step(); expect_st(5, "sr_lp");
        soft_reset = 3'b010;
        step(); expect_st(0, "sr_from_lp");
        soft_reset = 3'b000;

        // Reset while in FFS
        pkt_valid = 1'b1;
        step(); step(); fifo_full = 3'b010;
        step(); expect_st(4, "rst_ffs");
        reset = 1'b1;
        step(); expect_st(0, "rst_da");
        chk("rst_detect_add", 16'(detect_add), 16'd1);
        chk("rst_dest_sel", 16'(dest_sel), 16'd0);
        reset = 1'b0; fifo_full = '0; pkt_valid = 1'b0;

        // Eight-port build, highest address
        r8 = 1'b0; di8 = 3'd7; pv8 = 1'b1;
        step();
        chk("p8_lfd", 16'(st8), 16'd1);
        chk("p8_dest_sel", 16'(dsel8), 16'h80);
        step();
        chk("p8_ld", 16'(st8), 16'd3);
        pv8 = 1'b0;
        step();
        chk("p8_lp", 16'(st8), 16'd5);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 59) == 0);
            pkt_valid     = ($urandom_range(0, 9) < 8);
            data_in       = AW'($urandom_range(0, 3));
            parity_done   = ($urandom_range(0, 9) < 3);
            low_pkt_valid = ($urandom_range(0, 9) < 3);
            for (int b = 0; b < NP; b++) begin
                fifo_empty[b] = ($urandom_range(0, 1) == 1);
                fifo_full[b]  = ($urandom_range(0, 3) == 0);
                soft_reset[b] = ($urandom_range(0, 19) == 0);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
